// File: rtl/alu_share_arbiter.sv
// Shares one EX-stage ALU between the main pipeline (port 0) and the aux path (port 1),
// registering each result into a one-entry valid/ready slot. Optional macro: ALU_ARB_STARVE_EN.
module alu_share_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_opcode,
  input  logic [2:0]        req0_func3,
  input  logic              req0_func7,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_opcode,
  input  logic [2:0]        req1_func3,
  input  logic              req1_func7,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic [4:0]        alu_opcode,
  output logic [2:0]        alu_func3,
  output logic              alu_func7,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_branch_taken,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_taken,
  input  logic              rsp_ready0,
  input  logic              rsp_ready1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_taken_q, rsp_taken_d;
  logic                owner_ready, slot_free, grant1, hs0, hs1;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("alu_share_arbiter: MAX_WAIT must be in 1..15");
  end

  // Only the owning requester's ready can drain the slot.
  assign owner_ready = rsp_id_q ? rsp_ready1 : rsp_ready0;
  assign slot_free   = (state_q == EMPTY) || owner_ready;

`ifdef ALU_ARB_STARVE_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req1_valid || hs1) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign grant1 = req1_valid && (!req0_valid || (wait_cnt_q == 4'(MAX_WAIT)));
`else
  assign grant1 = req1_valid && !req0_valid;
`endif

  assign hs0        = req0_valid && slot_free && !grant1;
  assign hs1        = grant1 && slot_free;
  assign req0_ready = hs0;
  assign req1_ready = hs1;

  // Idle bus is driven to zero so the ALU sees no stale operands.
  always_comb begin
    alu_opcode = 5'd0;
    alu_func3  = 3'd0;
    alu_func7  = 1'b0;
    alu_op1    = '0;
    alu_op2    = '0;
    if (grant1) begin
      alu_opcode = req1_opcode;
      alu_func3  = req1_func3;
      alu_func7  = req1_func7;
      alu_op1    = req1_op1;
      alu_op2    = req1_op2;
    end else if (req0_valid) begin
      alu_opcode = req0_opcode;
      alu_func3  = req0_func3;
      alu_func7  = req0_func7;
      alu_op1    = req0_op1;
      alu_op2    = req0_op2;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_taken_d = rsp_taken_q;
    if (hs0 || hs1) begin
      state_d     = FULL;
      rsp_id_d    = hs1;
      rsp_data_d  = alu_out;
      rsp_taken_d = alu_branch_taken;
    end else if (state_q == FULL && owner_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_taken_q <= rsp_taken_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_taken = rsp_taken_q;

endmodule
